// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM CIC demodulator: internal width, parameter
// range check and output width reduction.
// Build option: define PDM_CIC_SAT_EN to saturate the output to OW bits;
// without it the output wraps to its low OW bits.
package pdm_pkg;

    localparam int SHIFT_W = 5;

    // Internal CIC width: bit growth of ORDER stages of DECIM plus sign and +-1 input.
    function automatic int cic_width(input int order, input int decim);
        return order * $clog2(decim) + 2;
    endfunction

    // Legal parameter ranges for the demodulator.
    function automatic bit params_ok(input int lines, input int order,
                                     input int decim, input int ow);
        return (lines >= 1) && (lines <= 4) &&
               (order >= 1) && (order <= 5) &&
               (decim >= 2) && (decim <= 256) &&
               (ow >= 8) && (ow <= 32);
    endfunction

    // Reduce a sign-extended sample to ow bits; the result is returned
    // sign-extended so the caller simply keeps the low ow bits.
    function automatic logic signed [63:0] reduce_out(input logic signed [63:0] v,
                                                      input int ow);
`ifdef PDM_CIC_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
`else
        logic signed [63:0] t;
        t = v <<< (64 - ow);
        return t >>> (64 - ow);
`endif
    endfunction

endpackage

// File: rtl/pdm_cic_channel.sv
// One CIC decimator channel: ORDER wrapping integrators at the PDM rate,
// ORDER combs at the frame rate, then shift and width reduction into a
// held output register.
module pdm_cic_channel
    import pdm_pkg::*;
#(
    parameter int ORDER = 4,
    parameter int W     = 26,
    parameter int OW    = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic               i_upd,
    input  logic               i_bit,
    input  logic               i_snap,
    input  logic               i_load,
    input  logic [SHIFT_W-1:0] i_shift,
    output logic [OW-1:0]      o_dout
);

    logic signed [W-1:0] r_integ [ORDER];
    logic signed [W-1:0] r_prev  [ORDER];
    logic signed [W-1:0] w_diff  [ORDER+1];
    logic signed [W-1:0] w_x;
    logic signed [W-1:0] w_shifted;
    logic signed [63:0]  w_ext;
    logic [OW-1:0]       w_red;
    logic [OW-1:0]       r_dout;

    // PDM bit 1 counts as +1, bit 0 as -1.
    assign w_x = i_bit ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};

    // Integrator chain; each stage adds the previous stage's registered value.
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            for (int k = 0; k < ORDER; k++) r_integ[k] <= '0;
        end else if (i_upd) begin
            r_integ[0] <= r_integ[0] + w_x;
            for (int k = 1; k < ORDER; k++) r_integ[k] <= r_integ[k] + r_integ[k-1];
        end
    end

    // Comb chain evaluated in one cycle from the last integrator snapshot.
    assign w_diff[0] = r_integ[ORDER-1];
    genvar gi;
    generate
        for (gi = 0; gi < ORDER; gi++) begin : g_comb
            assign w_diff[gi+1] = w_diff[gi] - r_prev[gi];
        end
    endgenerate

    // Comb delay elements advance once per frame, even if the frame is dropped.
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            for (int k = 0; k < ORDER; k++) r_prev[k] <= '0;
        end else if (i_snap) begin
            for (int k = 0; k < ORDER; k++) r_prev[k] <= w_diff[k];
        end
    end

    assign w_shifted = w_diff[ORDER] >>> i_shift;
    assign w_ext     = {{(64-W){w_shifted[W-1]}}, w_shifted};
    assign w_red     = OW'(reduce_out(w_ext, OW));

    // Output register only reloads when the top accepts a new frame.
    always_ff @(posedge clk) begin
        if (rst || !i_en)
            r_dout <= '0;
        else if (i_load)
            r_dout <= w_red;
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/pdm_cic_demodulator.sv
// Multi-line PDM to PCM demodulator: synchronises the PDM clock and data,
// demultiplexes two channels per line on ock rise/fall, runs one CIC
// decimator per channel and hands out frames with a valid/ready handshake
// plus a sticky overrun flag.
// Build option: PDM_CIC_SAT_EN selects output saturation instead of wrap.
module pdm_cic_demodulator
    import pdm_pkg::*;
#(
    parameter int LINES = 1,
    parameter int ORDER = 4,
    parameter int DECIM = 64,
    parameter int OW    = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    ock,
    input  logic [LINES-1:0]        sdi,
    input  logic [SHIFT_W-1:0]      shift,
    output logic [2*LINES*OW-1:0]   dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    ovr,
    input  logic                    clr_ovr
);

    localparam int CH = 2 * LINES;
    localparam int W  = cic_width(ORDER, DECIM);
    localparam int CW = $clog2(DECIM);

    genvar gi;
    generate
        if (!params_ok(LINES, ORDER, DECIM, OW)) begin : g_param_error
            $error("pdm_cic_demodulator: parameter out of range");
        end
    endgenerate

    logic               r_ock_s1, r_ock_s2, r_ock_s3;
    logic [LINES-1:0]   r_sdi_s1, r_sdi_s2;
    logic [CW-1:0]      r_fall_cnt;
    logic               r_frame_p1;
    logic [SHIFT_W-1:0] r_shift;
    logic               r_dout_valid;
    logic               r_ovr;
    logic               w_rise, w_fall;
    logic               w_frame_done;
    logic               w_load, w_drop;

    // Two-flop synchronisers; s3 is the previous synchronised ock for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ock_s1 <= 1'b0;
            r_ock_s2 <= 1'b0;
            r_ock_s3 <= 1'b0;
            r_sdi_s1 <= '0;
            r_sdi_s2 <= '0;
        end else begin
            r_ock_s1 <= ock;
            r_ock_s2 <= r_ock_s1;
            r_ock_s3 <= r_ock_s2;
            r_sdi_s1 <= sdi;
            r_sdi_s2 <= r_sdi_s1;
        end
    end

    assign w_rise       = r_ock_s2 & ~r_ock_s3;
    assign w_fall       = ~r_ock_s2 & r_ock_s3;
    assign w_frame_done = en & w_fall & (r_fall_cnt == CW'(DECIM - 1));

    // A new frame is only accepted when nothing is pending or the pending one leaves now.
    assign w_load = en & r_frame_p1 & ~(r_dout_valid & ~dout_ready);
    assign w_drop = en & r_frame_p1 & r_dout_valid & ~dout_ready;

    // Fall counter delimits frames; the frame strobe is delayed one cycle for the combs.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_fall_cnt <= '0;
            r_frame_p1 <= 1'b0;
        end else begin
            r_frame_p1 <= w_frame_done;
            if (w_fall)
                r_fall_cnt <= w_frame_done ? '0 : r_fall_cnt + 1'b1;
        end
    end

    // Shift is captured at frame completion so it stays coherent for that frame.
    always_ff @(posedge clk) begin
        if (rst)
            r_shift <= '0;
        else if (w_frame_done)
            r_shift <= shift;
    end

    // Output valid: set on an accepted frame, cleared on transfer.
    always_ff @(posedge clk) begin
        if (rst || !en)
            r_dout_valid <= 1'b0;
        else if (w_load)
            r_dout_valid <= 1'b1;
        else if (dout_ready)
            r_dout_valid <= 1'b0;
    end

    // Sticky overrun; a simultaneous drop wins over the clear, and en does not clear it.
    always_ff @(posedge clk) begin
        if (rst)
            r_ovr <= 1'b0;
        else if (w_drop)
            r_ovr <= 1'b1;
        else if (clr_ovr)
            r_ovr <= 1'b0;
    end

    // Even channels integrate on ock rise, odd channels on ock fall.
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic w_upd;
            if (gi % 2 == 0) begin : g_even
                assign w_upd = w_rise;
            end else begin : g_odd
                assign w_upd = w_fall;
            end

            pdm_cic_channel #(
                .ORDER (ORDER),
                .W     (W),
                .OW    (OW)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .i_en    (en),
                .i_upd   (w_upd),
                .i_bit   (r_sdi_s2[gi/2]),
                .i_snap  (r_frame_p1),
                .i_load  (w_load),
                .i_shift (r_shift),
                .o_dout  (dout[gi*OW +: OW])
            );
        end
    endgenerate

    assign dout_valid = r_dout_valid;
    assign ovr        = r_ovr;

endmodule

// File: tb/tb_pdm_cic_demodulator.sv
// Directed bench for pdm_cic_demodulator (LINES=1, ORDER=4, DECIM=64, OW=24).
// Settled full-scale output is +-2^24 before the shift.
module tb_pdm_cic_demodulator;

    localparam int DECIM = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        ock;
    logic [0:0]  sdi;
    logic [4:0]  shift;
    logic [47:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        ovr;
    logic        clr_ovr;

    int checks = 0;
    int errors = 0;
    bit tog    = 1'b1;

    always #5 clk = ~clk;

    pdm_cic_demodulator #(
        .LINES (1),
        .ORDER (4),
        .DECIM (DECIM),
        .OW    (24)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ock        (ock),
        .sdi        (sdi),
        .shift      (shift),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .ovr        (ovr),
        .clr_ovr    (clr_ovr)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One ock period (8 clk): rise half carries L, fall half carries R.
    // Called on a negedge; returns on the negedge of cycle T+2 after the fall's detect cycle T.
    task automatic pdm_cycle(input int lmode, input bit rbit, input bit lat_chk, input bit clr_end);
        ock = 1'b1;
        case (lmode)
            0:       sdi[0] = 1'b0;
            1:       sdi[0] = 1'b1;
            default: begin sdi[0] = tog; tog = ~tog; end
        endcase
        repeat (4) @(negedge clk);
        ock    = 1'b0;
        sdi[0] = rbit;
        @(negedge clk);
        @(negedge clk);           // detect cycle T
        @(negedge clk);           // T+1
        if (lat_chk) check("valid_T+1", dout_valid, 0);
        if (clr_end) clr_ovr = 1'b1;
        @(negedge clk);           // T+2
        clr_ovr = 1'b0;
        if (lat_chk) check("valid_T+2", dout_valid, 1);
    endtask

    task automatic cycles(input int n, input int lmode, input bit rbit,
                          input bit lat_last, input bit clr_last);
        for (int i = 0; i < n; i++)
            pdm_cycle(lmode, rbit, lat_last && (i == n - 1), clr_last && (i == n - 1));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; ock = 1'b0; sdi = '0; shift = 5'd2;
        dout_ready = 1'b1; clr_ovr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_ovr", ovr, 0);
        rst = 1'b0;
        en  = 1'b1;
        @(negedge clk);

        // Constant 1, shift 2, with latency check on the settling frame.
        cycles(5 * DECIM, 1, 1'b1, 1'b1, 1'b0);
        check("one_s2_L", $signed(dout[23:0]), 4194304);
        check("one_s2_R", $signed(dout[47:24]), 4194304);

        // Constant 1, shift 0: full scale exceeds 24 bits.
        shift = 5'd0;
        cycles(DECIM, 1, 1'b1, 1'b0, 1'b0);
`ifdef PDM_CIC_SAT_EN
        check("one_s0_L", $signed(dout[23:0]), 8388607);
        check("one_s0_R", $signed(dout[47:24]), 8388607);
`else
        check("one_s0_L", $signed(dout[23:0]), 0);
        check("one_s0_R", $signed(dout[47:24]), 0);
`endif

        // Constant 0, shift 2.
        shift = 5'd2;
        cycles(5 * DECIM, 0, 1'b0, 1'b0, 1'b0);
        check("zero_s2_L", $signed(dout[23:0]), -4194304);
        check("zero_s2_R", $signed(dout[47:24]), -4194304);

        // L toggles 1010 on rises, R constant 1.
        tog = 1'b1;
        cycles(5 * DECIM, 2, 1'b1, 1'b0, 1'b0);
        check("tog_L", $signed(dout[23:0]), 0);
        check("tog_R", $signed(dout[47:24]), 4194304);

        // Overrun: settle at +4194304, then stall the consumer.
        cycles(5 * DECIM, 1, 1'b1, 1'b0, 1'b0);
        dout_ready = 1'b0;        // the frame just presented stays pending
        check("pend_L", $signed(dout[23:0]), 4194304);
        check("pend_ovr", ovr, 0);
        cycles(DECIM, 0, 1'b0, 1'b0, 1'b0);
        check("ovr_held_L", $signed(dout[23:0]), 4194304);
        check("ovr_valid", dout_valid, 1);
        check("ovr_set", ovr, 1);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        check("ovr_clr", ovr, 0);
        cycles(DECIM, 0, 1'b0, 1'b0, 1'b1);
        check("ovr_set_wins", ovr, 1);
        check("ovr_held_L2", $signed(dout[23:0]), 4194304);
        dout_ready = 1'b1;
        @(negedge clk);
        check("xfer_valid", dout_valid, 0);

        // en low mid-frame clears outputs but keeps ovr.
        cycles(20, 1, 1'b1, 1'b0, 1'b0);
        en = 1'b0;
        @(negedge clk);
        check("en0_dout", dout, 0);
        check("en0_valid", dout_valid, 0);
        check("en0_ovr", ovr, 1);
        en = 1'b1;
        cycles(DECIM - 1, 1, 1'b1, 1'b0, 1'b0);
        check("en_63_valid", dout_valid, 0);
        cycles(1, 1, 1'b1, 1'b1, 1'b0);
        check("en_64_nz", (dout != 48'd0), 1);

        // rst mid-frame.
        cycles(20, 1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rst2_dout", dout, 0);
        check("rst2_valid", dout_valid, 0);
        check("rst2_ovr", ovr, 0);
        rst = 1'b0;
        cycles(DECIM - 1, 1, 1'b1, 1'b0, 1'b0);
        check("rst_63_valid", dout_valid, 0);
        cycles(1, 1, 1'b1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
